mux8to1_if: RTL and testbench

//  8-to-1 selector: routes one of eight input lanes D to output P under the 3-bit select S.
//  P is combinational; P_q is a registered copy for timing-closed consumers.

---
 rtl/mux8to1_if.sv | 81 ++++++++
 tb/tb_mux8to1_if.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mux8to1_if.sv
// 8-to-1 lane selector: combinational output P plus a registered copy P_q
// with a sticky valid flag that only reset clears.
module mux8to1_if #(
    parameter int DATA_W = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [8*DATA_W-1:0]   D,
    input  logic [2:0]            S,
    output logic [DATA_W-1:0]     P,
    output logic [DATA_W-1:0]     P_q,
    output logic                  q_vld
);

    logic [DATA_W-1:0] p_s;
    logic [DATA_W-1:0] pq_d;
    logic [DATA_W-1:0] pq_q;
    logic              vld_d;
    logic              vld_q;

    function automatic logic [DATA_W-1:0] lane(
        input logic [8*DATA_W-1:0] d,
        input int unsigned         k
    );
        return d[k*DATA_W +: DATA_W];
    endfunction

    // Select decode; an unknown select poisons the output so it is visible downstream.
    always_comb begin
        p_s = lane(D, 32'd7);
        if ($isunknown(S)) begin
            p_s = {DATA_W{1'bx}};
        end else if (S == 3'd0) begin
            p_s = lane(D, 32'd0);
        end else if (S == 3'd1) begin
            p_s = lane(D, 32'd1);
        end else if (S == 3'd2) begin
            p_s = lane(D, 32'd2);
        end else if (S == 3'd3) begin
            p_s = lane(D, 32'd3);
        end else if (S == 3'd4) begin
            p_s = lane(D, 32'd4);
        end else if (S == 3'd5) begin
            p_s = lane(D, 32'd5);
        end else if (S == 3'd6) begin
            p_s = lane(D, 32'd6);
        end else begin
            p_s = lane(D, 32'd7);
        end
    end

    // Next-state for the capture register: load on enable, otherwise hold.
    always_comb begin
        pq_d  = pq_q;
        vld_d = vld_q;
        if (en) begin
            pq_d  = p_s;
            vld_d = 1'b1;
        end else begin
            pq_d  = pq_q;
            vld_d = vld_q;
        end
    end

    // Capture register; synchronous reset wins over enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pq_q  <= {DATA_W{1'b0}};
            vld_q <= 1'b0;
        end else begin
            pq_q  <= pq_d;
            vld_q <= vld_d;
        end
    end

    assign P     = p_s;
    assign P_q   = pq_q;
    assign q_vld = vld_q;

endmodule

// File: tb/tb_mux8to1_if.sv
// Randomised scoreboard bench for mux8to1_if (DATA_W=1): the driver queues the
// expected outputs for each cycle, a negedge monitor pops and compares them.
module tb_mux8to1_if;

    localparam int DW = 1;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [8*DW-1:0] D;
    logic [2:0]    S;
    logic [DW-1:0] P;
    logic [DW-1:0] P_q;
    logic          q_vld;

    typedef struct {
        logic [DW-1:0] p;
        logic [DW-1:0] pq;
        logic          vld;
        string         tag;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: what the capture register should hold after each edge.
    logic [DW-1:0] m_pq;
    logic          m_vld;
    logic          cur_rst_n;
    logic          cur_en;
    logic [7:0]    cur_d;
    logic [2:0]    cur_s;

    mux8to1_if #(.DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .D     (D),
        .S     (S),
        .P     (P),
        .P_q   (P_q),
        .q_vld (q_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ref_sel(input logic [7:0] d, input logic [2:0] s);
        int unsigned v;
        v = (int'(d) >> (int'(s) * DW)) % (1 << DW);
        return v[DW-1:0];
    endfunction

    // One cycle: account for the edge just taken, then apply new inputs and queue expectations.
    task automatic step(input logic r, input logic e, input logic [7:0] d,
                        input logic [2:0] s, input string tag);
        exp_t x;
        @(posedge clk);
        if (!cur_rst_n) begin
            m_pq  = '0;
            m_vld = 1'b0;
        end else if (cur_en) begin
            m_pq  = ref_sel(cur_d, cur_s);
            m_vld = 1'b1;
        end
        #1;
        rst_n = r; en = e; D = d; S = s;
        cur_rst_n = r; cur_en = e; cur_d = d; cur_s = s;
        x.p   = ref_sel(d, s);
        x.pq  = m_pq;
        x.vld = m_vld;
        x.tag = tag;
        exp_q.push_back(x);
    endtask

    // Monitor: outputs are stable mid-cycle, compare against the oldest expectation.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                n_checks++;
                if (P !== x.p) begin
                    n_fail++;
                    $display("FAIL %s P: got %b expected %b (D=%h S=%0d)", x.tag, P, x.p, D, S);
                end
                n_checks++;
                if (P_q !== x.pq) begin
                    n_fail++;
                    $display("FAIL %s P_q: got %b expected %b", x.tag, P_q, x.pq);
                end
                n_checks++;
                if (q_vld !== x.vld) begin
                    n_fail++;
                    $display("FAIL %s q_vld: got %b expected %b", x.tag, q_vld, x.vld);
                end
            end
        end
    end

    initial begin
        logic [7:0] dv [8];
        logic [2:0] sv [8];
        int wait_cyc;
        rst_n = 1'b0; en = 1'b1; D = 8'hFF; S = 3'd0;
        cur_rst_n = 1'b0; cur_en = 1'b1; cur_d = 8'hFF; cur_s = 3'd0;
        m_pq = '0; m_vld = 1'b0;

        // Reset held with en=1 for two edges, then released.
        step(1'b0, 1'b1, 8'hFF, 3'd0, "rst_hold0");
        step(1'b0, 1'b1, 8'hFF, 3'd0, "rst_hold1");
        step(1'b1, 1'b1, 8'hFF, 3'd0, "rst_release");
        step(1'b1, 1'b0, 8'hFF, 3'd0, "first_load");

        dv = '{8'h00, 8'hFF, 8'hD0, 8'h38, 8'h50, 8'h28, 8'h88, 8'h48};
        sv = '{3'd0, 3'd7, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3};
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, dv[i], sv[i], "vector");

        for (int k = 0; k < 8; k++) begin
            for (int s = 0; s < 8; s++) begin
                step(1'b1, 1'($urandom_range(0, 1)), 8'(1 << k), 3'(s), "onehot");
            end
        end

        // Enable low: P follows, P_q holds; then reset mid-run.
        step(1'b1, 1'b1, 8'h01, 3'd0, "hold_load");
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'($urandom), 3'($urandom), "hold");
        step(1'b0, 1'b0, 8'hAA, 3'd1, "mid_rst");
        step(1'b1, 1'b0, 8'h55, 3'd0, "post_rst");
        step(1'b1, 1'b0, 8'h55, 3'd2, "post_rst_hold");

        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)),
                 8'($urandom), 3'($urandom), "random");
        end

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
